// File: rtl/uart_sram_loader_top.sv
// UART (8N1) to pipelined ZBT SRAM loader: stores words until 0xFFFFFFFF,
// reports the stored word count, then echoes each word through the SRAM.
module uart_sram_loader_top #(
    parameter logic [15:0] WTIME        = 16'h0006,
    parameter logic [19:0] SCRATCH_ADDR = 20'hFFFFF
) (
    input  logic        CLK,
    input  logic        XRST,
    input  logic        RS_RX,
    output logic        RS_TX,
    inout  wire  [31:0] ZD,
    inout  wire  [3:0]  ZDP,
    output logic [19:0] ZA,
    output logic        XE1,
    output logic        E2A,
    output logic        XE3,
    output logic [3:0]  XZBE,
    output logic        XGA,
    output logic        XWA,
    output logic        XZCKE,
    output logic [1:0]  ZCLKMA,
    output logic        ADVA,
    output logic        XFT,
    output logic        XLBO,
    output logic        ZZA
);

    localparam logic [15:0] WTIME_M1 = WTIME - 16'd1;
    localparam logic [15:0] HALF_M1  = (WTIME >> 1) - 16'd1;
    localparam logic [19:0] CNT_MAX  = 20'hFFFFF;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic       {PH_LOAD, PH_RUN} phase_t;

    rx_state_t   rx_state_q, rx_state_d;
    tx_state_t   tx_state_q, tx_state_d;
    phase_t      phase_q, phase_d;
    logic        rx_sync1_q, rx_sync1_d, rx_sync2_q, rx_sync2_d, rx_prev_q, rx_prev_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [1:0]  rx_byte_idx_q, rx_byte_idx_d;
    logic [31:0] rx_word_q, rx_word_d;
    logic        word_vld_q, word_vld_d;
    logic [19:0] count_q, count_d, za_q, za_d;
    logic        xwa_q, xwa_d, rd_req_q, rd_req_d;
    logic        wr_vld_p0_q, wr_vld_p0_d, wr_vld_p1_q, wr_vld_p1_d;
    logic [31:0] wr_data_p0_q, wr_data_p0_d, wr_data_p1_q, wr_data_p1_d;
    logic        zd_oe_q, zd_oe_d;
    logic [31:0] zd_q, zd_d;
    logic        rd_vld_p0_q, rd_vld_p0_d, rd_vld_p1_q, rd_vld_p1_d, rd_vld_p2_q, rd_vld_p2_d;
    logic        pend_vld_q, pend_vld_d, pend_new, tx_take;
    logic [31:0] pend_data_q, pend_data_d, pend_word;
    logic [31:0] tx_word_q, tx_word_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [1:0]  tx_byte_q, tx_byte_d;
    logic        rs_tx_q, rs_tx_d;
    logic [7:0]  tx_cur;

    assign XE1    = 1'b0;
    assign E2A    = 1'b1;
    assign XE3    = 1'b0;
    assign XZBE   = 4'b0000;
    assign XGA    = 1'b0;
    assign XZCKE  = 1'b0;
    assign ZCLKMA = {CLK, CLK};
    assign ADVA   = 1'b0;
    assign XFT    = 1'b1;
    assign XLBO   = 1'b1;
    assign ZZA    = 1'b0;

    assign ZD    = zd_oe_q ? zd_q : 32'bz;
    assign ZDP   = zd_oe_q ? 4'b0000 : 4'bz;
    assign ZA    = za_q;
    assign XWA   = xwa_q;
    assign RS_TX = rs_tx_q;

    always_comb begin
        rx_sync1_d    = RS_RX;
        rx_sync2_d    = rx_sync1_q;
        rx_prev_d     = rx_sync2_q;
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_byte_idx_d = rx_byte_idx_q;
        rx_word_d     = rx_word_q;
        word_vld_d    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_M1;
                end
            end
            RX_START: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = WTIME_M1;
                    rx_bit_d   = 3'd0;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = WTIME_M1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_state_d = RX_IDLE;
                    // A low stop bit is a framing error: the byte never reaches the word.
                    if (rx_sync2_q) begin
                        rx_word_d     = {rx_word_q[23:0], rx_shift_q};
                        rx_byte_idx_d = rx_byte_idx_q + 2'd1;
                        word_vld_d    = (rx_byte_idx_q == 2'd3);
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        phase_d      = phase_q;
        count_d      = count_q;
        rd_req_d     = 1'b0;
        xwa_d        = 1'b1;
        za_d         = za_q;
        wr_vld_p0_d  = 1'b0;
        wr_data_p0_d = wr_data_p0_q;
        rd_vld_p0_d  = 1'b0;
        pend_new     = 1'b0;
        pend_word    = 32'd0;
        // The scratch read goes out the cycle after its write.
        if (rd_req_q) begin
            za_d        = SCRATCH_ADDR;
            rd_vld_p0_d = 1'b1;
        end
        if (word_vld_q) begin
            if (phase_q == PH_LOAD) begin
                if (rx_word_q == 32'hFFFF_FFFF) begin
                    phase_d   = PH_RUN;
                    pend_new  = 1'b1;
                    pend_word = {12'd0, count_q};
                end else if (count_q != CNT_MAX) begin
                    xwa_d        = 1'b0;
                    za_d         = count_q;
                    wr_vld_p0_d  = 1'b1;
                    wr_data_p0_d = rx_word_q;
                    count_d      = count_q + 20'd1;
                end
            end else begin
                xwa_d        = 1'b0;
                za_d         = SCRATCH_ADDR;
                wr_vld_p0_d  = 1'b1;
                wr_data_p0_d = rx_word_q;
                rd_req_d     = 1'b1;
            end
        end

        // SRAM pipeline: stage p0 = address cycle, data phase two cycles later
        wr_vld_p1_d  = wr_vld_p0_q;
        wr_data_p1_d = wr_data_p0_q;
        zd_oe_d      = wr_vld_p1_q;
        zd_d         = wr_data_p1_q;
        rd_vld_p1_d  = rd_vld_p0_q;
        rd_vld_p2_d  = rd_vld_p1_q;
        if (rd_vld_p2_q) begin
            pend_new  = 1'b1;
            pend_word = ZD;
        end

        tx_take     = (tx_state_q == TX_IDLE) && pend_vld_q;
        pend_vld_d  = pend_vld_q && !tx_take;
        pend_data_d = pend_data_q;
        if (pend_new) begin
            pend_vld_d  = 1'b1;
            pend_data_d = pend_word;
        end

        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        tx_word_d  = tx_word_q;
        rs_tx_d    = rs_tx_q;
        tx_cur     = tx_word_q[31:24];
        unique case (tx_state_q)
            TX_IDLE: begin
                rs_tx_d = 1'b1;
                if (pend_vld_q) begin
                    tx_state_d = TX_SEND;
                    tx_word_d  = pend_data_q;
                    tx_byte_d  = 2'd0;
                    tx_bit_d   = 4'd0;
                    tx_cnt_d   = WTIME_M1;
                    rs_tx_d    = 1'b0;
                end
            end
            TX_SEND: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = WTIME_M1;
                    if (tx_bit_q == 4'd9) begin
                        if (tx_byte_q == 2'd3) begin
                            tx_state_d = TX_IDLE;
                        end else begin
                            tx_byte_d = tx_byte_q + 2'd1;
                            tx_bit_d  = 4'd0;
                            tx_word_d = {tx_word_q[23:0], 8'h00};
                            rs_tx_d   = 1'b0;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                        rs_tx_d  = (tx_bit_q == 4'd8) ? 1'b1 : tx_cur[tx_bit_q[2:0]];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            rx_sync1_q    <= 1'b1;
            rx_sync2_q    <= 1'b1;
            rx_prev_q     <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= 16'd0;
            rx_bit_q      <= 3'd0;
            rx_byte_idx_q <= 2'd0;
            word_vld_q    <= 1'b0;
            phase_q       <= PH_LOAD;
            count_q       <= 20'd0;
            za_q          <= 20'd0;
            xwa_q         <= 1'b1;
            rd_req_q      <= 1'b0;
            wr_vld_p0_q   <= 1'b0;
            wr_vld_p1_q   <= 1'b0;
            zd_oe_q       <= 1'b0;
            rd_vld_p0_q   <= 1'b0;
            rd_vld_p1_q   <= 1'b0;
            rd_vld_p2_q   <= 1'b0;
            pend_vld_q    <= 1'b0;
            tx_state_q    <= TX_IDLE;
            tx_cnt_q      <= 16'd0;
            tx_bit_q      <= 4'd0;
            tx_byte_q     <= 2'd0;
            rs_tx_q       <= 1'b1;
        end else begin
            rx_sync1_q    <= rx_sync1_d;
            rx_sync2_q    <= rx_sync2_d;
            rx_prev_q     <= rx_prev_d;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_byte_idx_q <= rx_byte_idx_d;
            word_vld_q    <= word_vld_d;
            phase_q       <= phase_d;
            count_q       <= count_d;
            za_q          <= za_d;
            xwa_q         <= xwa_d;
            rd_req_q      <= rd_req_d;
            wr_vld_p0_q   <= wr_vld_p0_d;
            wr_vld_p1_q   <= wr_vld_p1_d;
            zd_oe_q       <= zd_oe_d;
            rd_vld_p0_q   <= rd_vld_p0_d;
            rd_vld_p1_q   <= rd_vld_p1_d;
            rd_vld_p2_q   <= rd_vld_p2_d;
            pend_vld_q    <= pend_vld_d;
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_bit_q      <= tx_bit_d;
            tx_byte_q     <= tx_byte_d;
            rs_tx_q       <= rs_tx_d;
        end
    end

    // Datapath registers carry no reset; their valids are reset above.
    always_ff @(posedge CLK) begin
        rx_shift_q   <= rx_shift_d;
        rx_word_q    <= rx_word_d;
        wr_data_p0_q <= wr_data_p0_d;
        wr_data_p1_q <= wr_data_p1_d;
        zd_q         <= zd_d;
        pend_data_q  <= pend_data_d;
        tx_word_q    <= tx_word_d;
    end

endmodule

// File: tb/tb_uart_sram_loader_top.sv
// Scoreboard bench for uart_sram_loader_top: ZBT SRAM model, UART TX decoder,
// directed word streams with hand-computed expected writes and TX bytes.
module tb_uart_sram_loader_top;

    localparam int WT = 6;

    logic CLK   = 1'b0;
    logic XRST  = 1'b1;
    logic RS_RX = 1'b1;

    wire        RS_TX;
    wire [31:0] ZD;
    wire [3:0]  ZDP;
    wire [19:0] ZA;
    wire        XE1, E2A, XE3, XGA, XWA, XZCKE, ADVA, XFT, XLBO, ZZA;
    wire [3:0]  XZBE;
    wire [1:0]  ZCLKMA;

    always #7 CLK = ~CLK;

    uart_sram_loader_top #(.WTIME(16'h0006), .SCRATCH_ADDR(20'hFFFFF)) dut (
        .CLK(CLK), .XRST(XRST), .RS_RX(RS_RX), .RS_TX(RS_TX),
        .ZD(ZD), .ZDP(ZDP), .ZA(ZA), .XE1(XE1), .E2A(E2A), .XE3(XE3),
        .XZBE(XZBE), .XGA(XGA), .XWA(XWA), .XZCKE(XZCKE), .ZCLKMA(ZCLKMA),
        .ADVA(ADVA), .XFT(XFT), .XLBO(XLBO), .ZZA(ZZA)
    );

    typedef struct packed {
        logic [19:0] a;
        logic [31:0] d;
    } wr_t;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [7:0]  exp_tx[$];
    wr_t         exp_wr[$];
    logic [31:0] mem [bit [19:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // SRAM model: op seen in cycle c is driven back (read) or checked (write) in cycle c+2
    logic        op_vld = 1'b0, op_we = 1'b0;
    logic [19:0] op_a = '0;
    logic        s1_vld = 1'b0, s1_we = 1'b0, s2_vld = 1'b0, s2_we = 1'b0;
    logic [19:0] s1_a = '0, s2_a = '0;
    logic        tb_drv = 1'b0;
    logic [31:0] tb_rdata = '0;

    assign ZD = tb_drv ? tb_rdata : 32'bz;

    always @(posedge CLK) begin
        s1_vld   <= op_vld;
        s1_we    <= op_we;
        s1_a     <= op_a;
        s2_vld   <= s1_vld;
        s2_we    <= s1_we;
        s2_a     <= s1_a;
        tb_drv   <= s1_vld && !s1_we;
        tb_rdata <= mem.exists(s1_a) ? mem[s1_a] : 32'hA5A5_A5A5;
    end

    initial begin
        wr_t e;
        forever begin
            @(negedge CLK);
            op_vld = 1'b1;
            op_we  = !XWA;
            op_a   = ZA;
            if (s2_vld && s2_we) begin
                mem[s2_a] = ZD;
                if (exp_wr.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_write: addr %h data %h with none expected", s2_a, ZD);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", {12'd0, s2_a}, {12'd0, e.a});
                    chk("wr_data", ZD, e.d);
                    chk("wr_zdp", {28'd0, ZDP}, 32'd0);
                end
            end
        end
    end

    // UART decoder on RS_TX, sampling bit centres on the falling clock edge
    initial begin
        logic [7:0] b;
        logic       stop;
        @(posedge XRST);
        forever begin
            @(negedge CLK);
            if (XRST && RS_TX == 1'b0) begin
                repeat (WT / 2) @(negedge CLK);
                for (int i = 0; i < 8; i++) begin
                    repeat (WT) @(negedge CLK);
                    b[i] = RS_TX;
                end
                repeat (WT) @(negedge CLK);
                stop = RS_TX;
                if (exp_tx.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_tx: byte %h with none expected", b);
                end else begin
                    chk("tx_byte", {24'd0, b}, {24'd0, exp_tx.pop_front()});
                end
                chk("tx_stop", {31'd0, stop}, 32'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        RS_RX = 1'b0;
        repeat (WT) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RS_RX = b[i];
            repeat (WT) @(negedge CLK);
        end
        RS_RX = stop_bit;
        repeat (WT) @(negedge CLK);
        RS_RX = 1'b1;
        repeat (stop_bit ? 1 : WT) @(negedge CLK);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
    endtask

    task automatic push_tx(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(w[i*8 +: 8]);
    endtask

    task automatic push_wr(input logic [19:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0) && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        chk(name, exp_tx.size() + exp_wr.size(), 32'd0);
        repeat (20) @(negedge CLK);
    endtask

    task automatic do_reset();
        XRST  = 1'b0;
        RS_RX = 1'b1;
        repeat (4) @(negedge CLK);
        chk("rst_rs_tx", {31'd0, RS_TX}, 32'd1);
        chk("rst_xwa", {31'd0, XWA}, 32'd1);
        chk("rst_za", {12'd0, ZA}, 32'd0);
        XRST = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        #1 XRST = 1'b0;
        repeat (4) @(negedge CLK);
        chk("rst_rs_tx", {31'd0, RS_TX}, 32'd1);
        chk("rst_xwa", {31'd0, XWA}, 32'd1);
        chk("rst_za", {12'd0, ZA}, 32'd0);
        chk("rst_zd_released", ZD, 32'hA5A5_A5A5);
        XRST = 1'b1;
        chk("tie_offs", {19'd0, XE1, E2A, XE3, XZBE, XGA, XZCKE, ADVA, XFT, XLBO, ZZA}, 32'h806);
        chk("zclkma_lo", {30'd0, ZCLKMA}, 32'd0);
        @(posedge CLK);
        #1 chk("zclkma_hi", {30'd0, ZCLKMA}, 32'd3);
        repeat (50) @(negedge CLK);
        chk("idle_rs_tx", {31'd0, RS_TX}, 32'd1);
        chk("idle_xwa", {31'd0, XWA}, 32'd1);

        // Immediate marker, then one loopback word
        push_tx(32'h0000_0000);
        send_word(32'hFFFF_FFFF);
        push_wr(20'hFFFFF, 32'h0000_000A);
        push_tx(32'h0000_000A);
        send_word(32'h0000_000A);
        drain("drain_marker_loopback");

        // Three stored words, count report, then a loopback
        do_reset();
        push_wr(20'h00000, 32'h1234_5678);
        send_word(32'h1234_5678);
        push_wr(20'h00001, 32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF);
        push_wr(20'h00002, 32'h0000_0001);
        send_word(32'h0000_0001);
        push_tx(32'h0000_0003);
        send_word(32'hFFFF_FFFF);
        push_wr(20'hFFFFF, 32'hCAFE_F00D);
        push_tx(32'hCAFE_F00D);
        send_word(32'hCAFE_F00D);
        drain("drain_load3");
        chk("mem0", mem[20'h00000], 32'h1234_5678);
        chk("mem1", mem[20'h00001], 32'hDEAD_BEEF);
        chk("mem2", mem[20'h00002], 32'h0000_0001);

        // Framing error byte is dropped
        do_reset();
        send_byte(8'hA5, 1'b0);
        push_tx(32'h0000_0000);
        send_word(32'hFFFF_FFFF);
        drain("drain_framing");

        // Reset in the middle of the second byte discards partial data
        send_byte(8'h12, 1'b1);
        RS_RX = 1'b0;
        repeat (WT) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            RS_RX = (i == 2);
            repeat (WT) @(negedge CLK);
        end
        do_reset();
        push_tx(32'h0000_0000);
        send_word(32'hFFFF_FFFF);
        drain("drain_midframe_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_sram_loader_top.md
Name: uart_sram_loader_top

Overview:
- Board-level top for the SRAM/UART bring-up path.
- Receives 32-bit words over an RS-232C line (8N1) and stores them sequentially in an external pipelined ZBT SRAM until the end marker 0xFFFFFFFF arrives.
- After the end marker it reports the loaded word count, then runs an SRAM loopback service: every further received word is written to SRAM, read back, and echoed on the TX line.

Parameters:
- WTIME, 16'h0006: clocks per UART bit, used for both RX and TX. With the 14 ns clock this gives 84 ns per bit.
- SCRATCH_ADDR, 20'hFFFFF: SRAM word address used for run-phase loopback.

Ports:
- CLK  in  1  system clock.
- XRST  in  1  reset.
- RS_RX  in  1  UART receive line; idle high.
- RS_TX  out  1  UART transmit line; idle high.
- ZD  inout  32  SRAM data.
- ZDP  inout  4  SRAM parity; always driven 0 on writes, ignored on reads.
- ZA  out  20  SRAM word address.
- XE1  out  1  tied 0.
- E2A  out  1  tied 1.
- XE3  out  1  tied 0.
- XZBE  out  4  byte enables, active low; tied 0000.
- XGA  out  1  output enable, active low; tied 0.
- XWA  out  1  write enable, active low.
- XZCKE  out  1  tied 0.
- ZCLKMA  out  2  both bits equal CLK.
- ADVA  out  1  tied 0.
- XFT  out  1  tied 1 (pipelined mode).
- XLBO  out  1  tied 1.
- ZZA  out  1  tied 0.

Behaviour:
- Reset: one clock, CLK. XRST is asynchronous and active-low.
- Reset values: RS_TX=1, XWA=1, ZA=0, ZD/ZDP tri-stated, phase=LOAD, count=0, RX/TX FSMs idle, pending word cleared. Reset mid-byte or mid-word discards all partial data.

UART receiver:
- Start is detected on a falling edge of RS_RX while idle.
- Each bit is sampled at its centre: WTIME/2 clocks after the start edge, then every WTIME clocks.
- Data is 8 bits, LSB first.
- If the stop bit samples 0, the byte is dropped (framing error) and the receiver returns to idle.
- Bytes are assembled big-endian: the first byte received becomes bits 31:24. The byte counter wraps every 4 bytes, producing one word.

UART transmitter:
- Frame is start(0), 8 data bits LSB first, stop(1). Each bit is held exactly WTIME clocks.
- Words are sent as 4 bytes, MSB first, back-to-back with no idle gap.

LOAD phase:
- A word other than 0xFFFFFFFF is written to SRAM at address count, then count is incremented.
- Once count reaches 0xFFFFF (equal to SCRATCH_ADDR), further non-marker words are discarded and count saturates.
- Word 0xFFFFFFFF switches phase to RUN and queues count (32-bit, zero-extended) for transmission. The marker itself is not stored.

RUN phase:
- For each word W: write W to SCRATCH_ADDR, then issue a read of SCRATCH_ADDR, then transmit the read-back value.

SRAM protocol (ZBT, pipelined, 2-cycle latency):
- Write: in cycle t, drive ZA and XWA=0. In cycle t+2, drive ZD=data and ZDP=0. Release the bus in cycle t+3.
- Read: in cycle t, drive ZA and XWA=1. Capture ZD at the end of cycle t+2.
- Only one SRAM operation starts per cycle. A read to the same address is issued no earlier than the cycle after the write.

Transmit queueing:
- If a word is ready to transmit while TX is busy, it is held in one pending register.
- A second pending word while the register is full is impossible at these rates, since a word takes 40 bit-times to arrive and 40 bit-times to send. No overflow handling is required.

Simultaneous events:
- An RX word completion and a TX completion in the same cycle are both honoured. TX takes the pending word on the next cycle.

Test Plan:
- Reset, hold RS_RX=1 → RS_TX stays 1, XWA=1, ZD high-Z, no SRAM accesses.
- Send bytes FF FF FF FF at 6 clk/bit → TX emits 00 00 00 00; phase=RUN; no SRAM write occurs.
- Then send 00 00 00 0A → one write of 0x0000000A at ZA=0xFFFFF (ZD driven 2 cycles after address), one read of 0xFFFFF, TX emits 00 00 00 0A.
- Reset; send 12345678, DEADBEEF, 00000001, then FFFFFFFF → SRAM[0..2] hold those values; TX emits 00 00 00 03.
- Send a byte with its stop bit forced to 0, then 4 valid bytes FF×4 → the bad byte is ignored and the marker is still recognised (TX 00 00 00 00).
- Assert XRST low mid-frame during the second byte, release, send FF×4 → count report is 00 00 00 00; RS_TX is 1 during reset.
